// File: rtl/jtag_sync.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_sync
//  Description : Clock-domain front end between a Virtual JTAG instance and
//                jtag_memory. Synchronizes raw TCK/TDI, the SDR/CDR/UDR/UIR
//                state flags and the instruction register into iCLK, and
//                regenerates a clean oTCK whose rising edge follows its data
//                outputs by one iCLK. Latches the address on UIR and returns
//                TDO to the JTAG side through a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_sync #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int SYNC_STAGES   = 2,
    localparam int IR_WIDTH     = 2 * ADDRESS_WIDTH + 1
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iRAW_TCK,
    input  logic                iRAW_TDI,
    input  logic                iRAW_SDR,
    input  logic                iRAW_CDR,
    input  logic                iRAW_UDR,
    input  logic                iRAW_UIR,
    input  logic [IR_WIDTH-1:0] iRAW_IR,
    output logic                oRAW_TDO,
    output logic                oTCK,
    output logic                oTDI,
    output logic                oSTATE_SDR,
    output logic                oSTATE_CDR,
    output logic                oSTATE_UDR,
    output logic [IR_WIDTH-1:0] oADDRESS,
    input  logic                iTDO,
    output logic                oERR
);

    // ------------------------------------------------------------------------
    // Raw input bus layout. Every raw signal rides in one vector so that all
    // of them see exactly the same synchronizer depth and stay aligned.
    // ------------------------------------------------------------------------
    localparam int c_BIT_TCK    = 0;
    localparam int c_BIT_TDI    = 1;
    localparam int c_BIT_SDR    = 2;
    localparam int c_BIT_CDR    = 3;
    localparam int c_BIT_UDR    = 4;
    localparam int c_BIT_UIR    = 5;
    localparam int c_BIT_IR_LO  = 6;
    localparam int c_BUS_WIDTH  = IR_WIDTH + 6;

    // Pulse regenerator state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_HIGH  = 2'd2;

    logic [c_BUS_WIDTH-1:0]                  w_rawBus;
    logic [SYNC_STAGES-1:0][c_BUS_WIDTH-1:0] r_syncChain;
    logic [c_BUS_WIDTH-1:0]                  w_syncBus;
    logic [SYNC_STAGES-1:0]                  r_syncValid;

    logic                w_tckS;
    logic                w_tdiS;
    logic                w_sdrS;
    logic                w_cdrS;
    logic                w_udrS;
    logic                w_uirS;
    logic [IR_WIDTH-1:0] w_irS;

    logic                r_tckD;
    logic                r_uirD;
    logic                r_tckArmed;
    logic                w_tckRise;
    logic                w_flagConflict;

    logic [1:0]          r_state;

    logic                r_uirRise;
    logic [IR_WIDTH-1:0] r_irCapture;

    assign w_rawBus = {iRAW_IR, iRAW_UIR, iRAW_UDR, iRAW_CDR,
                       iRAW_SDR, iRAW_TDI, iRAW_TCK};

    // Shift every raw bit through its own SYNC_STAGES-deep flop chain
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], w_rawBus};
        end
    end

    assign w_syncBus = r_syncChain[SYNC_STAGES-1];
    assign w_tckS    = w_syncBus[c_BIT_TCK];
    assign w_tdiS    = w_syncBus[c_BIT_TDI];
    assign w_sdrS    = w_syncBus[c_BIT_SDR];
    assign w_cdrS    = w_syncBus[c_BIT_CDR];
    assign w_udrS    = w_syncBus[c_BIT_UDR];
    assign w_uirS    = w_syncBus[c_BIT_UIR];
    assign w_irS     = w_syncBus[c_BUS_WIDTH-1:c_BIT_IR_LO];

    // Track how far real post-reset samples have advanced down the chain;
    // the last bit says the synchronized outputs no longer hold reset zeros.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_syncValid <= '0;
        end else begin
            r_syncValid <= {r_syncValid[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge-detect history for TCK and UIR, plus the TCK arm flag. A TCK rise
    // is only honoured once a genuine low has been seen after reset, so a raw
    // TCK that is still high when reset releases cannot fake a rising edge.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_tckD     <= 1'b0;
            r_uirD     <= 1'b0;
            r_tckArmed <= 1'b0;
        end else begin
            r_tckD <= w_tckS;
            r_uirD <= w_uirS;
            if (r_syncValid[SYNC_STAGES-1] && !w_tckS) begin
                r_tckArmed <= 1'b1;
            end
        end
    end

    assign w_tckRise      = r_tckArmed & w_tckS & ~r_tckD;
    assign w_flagConflict = (w_sdrS & w_cdrS) | (w_sdrS & w_udrS) |
                            (w_cdrS & w_udrS);

    // Pulse regenerator: load data on a synchronized TCK rise, hold it low
    // for one setup cycle, then drive oTCK high until synchronized TCK falls.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state    <= c_ST_IDLE;
            oTCK       <= 1'b0;
            oTDI       <= 1'b0;
            oSTATE_SDR <= 1'b0;
            oSTATE_CDR <= 1'b0;
            oSTATE_UDR <= 1'b0;
            oERR       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    oTCK <= 1'b0;
                    if (w_tckRise) begin
                        oTDI       <= w_tdiS;
                        oSTATE_SDR <= w_sdrS;
                        oSTATE_CDR <= w_cdrS;
                        oSTATE_UDR <= w_udrS;
                        if (w_flagConflict) begin
                            oERR <= 1'b1;
                        end
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    // Always go high so even a glitch yields a full-cycle pulse
                    oTCK    <= 1'b1;
                    r_state <= c_ST_HIGH;
                end
                c_ST_HIGH: begin
                    if (!w_tckS) begin
                        oTCK    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    oTCK    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Address capture: a synchronized UIR rise snapshots the synchronized IR,
    // which is then presented on oADDRESS one edge later.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_uirRise   <= 1'b0;
            r_irCapture <= '0;
            oADDRESS    <= '1;
        end else begin
            r_uirRise   <= w_uirS & ~r_uirD;
            r_irCapture <= w_irS;
            if (r_uirRise) begin
                oADDRESS <= r_irCapture;
            end
        end
    end

    // TDO return path: plain one-cycle register, no gating
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oRAW_TDO <= 1'b0;
        end else begin
            oRAW_TDO <= iTDO;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_sync
//  Description : Self-checking bench for jtag_sync. A cycle model built from
//                delayed raw samples and pulse rules predicts every output on
//                every cycle; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_sync;

    localparam int ADDRESS_WIDTH = 5;
    localparam int SYNC_STAGES   = 2;
    localparam int IR_WIDTH      = 2 * ADDRESS_WIDTH + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstN;
    logic                rawTck, rawTdi, rawSdr, rawCdr, rawUdr, rawUir;
    logic [IR_WIDTH-1:0] rawIr;
    logic                tdoIn;
    logic                oRawTdo, oTck, oTdi, oSdr, oCdr, oUdr, oErr;
    logic [IR_WIDTH-1:0] oAddr;

    jtag_sync #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rstN),
        .iRAW_TCK   (rawTck),
        .iRAW_TDI   (rawTdi),
        .iRAW_SDR   (rawSdr),
        .iRAW_CDR   (rawCdr),
        .iRAW_UDR   (rawUdr),
        .iRAW_UIR   (rawUir),
        .iRAW_IR    (rawIr),
        .oRAW_TDO   (oRawTdo),
        .oTCK       (oTck),
        .oTDI       (oTdi),
        .oSTATE_SDR (oSdr),
        .oSTATE_CDR (oCdr),
        .oSTATE_UDR (oUdr),
        .oADDRESS   (oAddr),
        .iTDO       (tdoIn),
        .oERR       (oErr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: synchronized view = raw sample SYNC_STAGES edges old
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic                tck;
        logic                tdi;
        logic                sdr;
        logic                cdr;
        logic                udr;
        logic                uir;
        logic [IR_WIDTH-1:0] ir;
    } rawSample_t;

    rawSample_t          hist[$];
    int                  sinceReset;
    int                  edgeIdx = 0;
    int                  loadEdge;
    bit                  armed;
    bit                  addrPend;
    bit                  modelValid = 0;
    logic [IR_WIDTH-1:0] addrNext;
    logic                mTck, mTdi, mSdr, mCdr, mUdr, mErr, mTdo;
    logic [IR_WIDTH-1:0] mAddr;

    always @(posedge clk) begin
        rawSample_t cur, view, prev;
        cur = '{tck: rawTck, tdi: rawTdi, sdr: rawSdr, cdr: rawCdr,
                udr: rawUdr, uir: rawUir, ir: rawIr};
        edgeIdx++;
        modelValid = 1;
        if (!rstN) begin
            hist.delete();
            for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
            sinceReset = 0;
            armed      = 0;
            loadEdge   = -1;
            addrPend   = 0;
            addrNext   = '0;
            mTck = 0; mTdi = 0; mSdr = 0; mCdr = 0; mUdr = 0; mErr = 0; mTdo = 0;
            mAddr = '1;
        end else begin
            view = hist[SYNC_STAGES-1];
            prev = hist[SYNC_STAGES];
            mTdo = tdoIn;
            // address: synced UIR rise, shown one edge after it is seen
            if (addrPend) mAddr = addrNext;
            addrPend = view.uir && !prev.uir;
            addrNext = view.ir;
            // pulse: low for the load edge, high from the next edge until
            // the synchronized TCK is seen low
            if (loadEdge >= 0) begin
                if (edgeIdx == loadEdge + 1) begin
                    mTck = 1;
                end else if (!view.tck) begin
                    mTck     = 0;
                    loadEdge = -1;
                end
            end else if (armed && view.tck && !prev.tck) begin
                loadEdge = edgeIdx;
                mTdi = view.tdi;
                mSdr = view.sdr;
                mCdr = view.cdr;
                mUdr = view.udr;
                if (int'(view.sdr) + int'(view.cdr) + int'(view.udr) >= 2) mErr = 1;
            end
            if (sinceReset >= SYNC_STAGES && !view.tck) armed = 1;
            sinceReset++;
            hist.push_front(cur);
            void'(hist.pop_back());
        end
    end

    // ------------------------------------------------------------------------
    // Compare process plus oTCK pulse monitor, sampled on the falling edge
    // ------------------------------------------------------------------------
    int   riseCount = 0;
    int   highWidth = 0;
    int   lastWidth = 0;
    logic prevTck   = 1'bx;
    logic capTdi[$];

    always @(negedge clk) begin
        if (modelValid) begin
            check("model_tck",  oTck,    mTck);
            check("model_tdi",  oTdi,    mTdi);
            check("model_sdr",  oSdr,    mSdr);
            check("model_cdr",  oCdr,    mCdr);
            check("model_udr",  oUdr,    mUdr);
            check("model_err",  oErr,    mErr);
            check("model_tdo",  oRawTdo, mTdo);
            check("model_addr", oAddr,   mAddr);
        end
        if (oTck === 1'b1 && prevTck === 1'b0) begin
            riseCount++;
            capTdi.push_back(oTdi);
            highWidth = 1;
        end else if (oTck === 1'b1) begin
            highWidth++;
        end else if (oTck === 1'b0 && prevTck === 1'b1) begin
            lastWidth = highWidth;
        end
        prevTck = oTck;
    end

    // Wall-clock bound so the bench never hangs
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        int               base;
        int               capBase;
        int               waitCycles;
        logic [15:0]      pat;
        logic [15:0]      got16;
        logic [3:0]       got4;

        rstN = 1'b0;
        {rawTck, rawTdi, rawSdr, rawCdr, rawUdr, rawUir} = '0;
        rawIr = '0;
        tdoIn = 1'b0;

        // reset held with raw inputs toggling
        for (int i = 0; i < 3; i++) begin
            {rawTck, rawTdi, rawSdr, rawCdr, rawUdr, rawUir} = 6'($urandom);
            rawIr = IR_WIDTH'($urandom);
            tdoIn = ~tdoIn;
            tick();
            check("rst_tck",  oTck,    1'b0);
            check("rst_sdr",  oSdr,    1'b0);
            check("rst_cdr",  oCdr,    1'b0);
            check("rst_udr",  oUdr,    1'b0);
            check("rst_err",  oErr,    1'b0);
            check("rst_tdo",  oRawTdo, 1'b0);
            check("rst_addr", oAddr,   11'h7FF);
        end
        {rawTck, rawTdi, rawSdr, rawCdr, rawUdr, rawUir} = '0;
        rawIr = '0;
        rstN  = 1'b1;
        tdoIn = 1'b1;
        tick(8);
        check("tdo_pass", oRawTdo, 1'b1);

        // single TCK pulse with TDI=1, SDR=1
        rawTdi = 1'b1;
        rawSdr = 1'b1;
        rawTck = 1'b1;
        tick(2);
        check("t2_tdi_pre", oTdi, 1'b0);
        tick();
        check("t2_tck_e3", oTck, 1'b0);
        check("t2_tdi_e3", oTdi, 1'b1);
        check("t2_sdr_e3", oSdr, 1'b1);
        tick();
        check("t2_tck_e4", oTck, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_tdi_hold", oTdi, 1'b1);
            check("t2_tck_hold", oTck, 1'b1);
        end
        rawTck = 1'b0;
        tick(2);
        check("t2_fall_e2", oTck, 1'b1);
        tick();
        check("t2_fall_e3", oTck, 1'b0);
        rawTdi = 1'b0;
        rawSdr = 1'b0;
        tick(4);

        // address capture on UIR
        rawIr  = 11'b1_00011_00010;
        rawUir = 1'b1;
        tick(2);
        check("t3_addr_e2", oAddr, 11'h7FF);
        tick(2);
        check("t3_addr_e4", oAddr, 11'h462);
        tick();
        rawUir = 1'b0;
        tick(3);
        rawIr = 11'h155;
        tick(10);
        check("t3_addr_hold", oAddr, 11'h462);

        // conflicting state flags set the sticky error
        rawCdr = 1'b1;
        rawUdr = 1'b1;
        rawTck = 1'b1;
        tick(2);
        check("t4_err_pre", oErr, 1'b0);
        tick();
        check("t4_err_set", oErr, 1'b1);
        check("t4_cdr",     oCdr, 1'b1);
        check("t4_udr",     oUdr, 1'b1);
        tick(3);
        rawTck = 1'b0;
        rawCdr = 1'b0;
        rawUdr = 1'b0;
        tick(8);
        check("t4_err_sticky", oErr, 1'b1);
        rstN = 1'b0;
        tick();
        check("t4_err_rst", oErr, 1'b0);
        rstN = 1'b1;
        tick(6);

        // one-cycle raw TCK glitch -> one one-cycle pulse
        base   = riseCount;
        rawTck = 1'b1;
        tick();
        rawTck = 1'b0;
        tick(8);
        check("t5_glitch_count", riseCount - base, 1);
        check("t5_glitch_width", lastWidth, 1);

        // 20-pulse burst at f(iCLK)/12 with TDI pattern 0xA5A5
        pat     = 16'hA5A5;
        base    = riseCount;
        capBase = capTdi.size();
        for (int i = 0; i < 20; i++) begin
            rawTdi = pat[15 - (i % 16)];
            rawTck = 1'b1;
            tick(6);
            rawTck = 1'b0;
            tick(6);
        end
        rawTdi = 1'b0;
        tick(8);
        check("t5_burst_count", riseCount - base, 20);
        got16 = '0;
        got4  = '0;
        if (capTdi.size() >= capBase + 20) begin
            for (int i = 0; i < 16; i++) got16[15 - i] = capTdi[capBase + i];
            for (int i = 0; i < 4; i++)  got4[3 - i]   = capTdi[capBase + 16 + i];
        end
        check("t5_burst_tdi16", got16, 16'hA5A5);
        check("t5_burst_tdi4",  got4,  4'hA);

        // reset while oTCK is high, raw TCK still high after release
        rawTck     = 1'b1;
        waitCycles = 0;
        while (oTck !== 1'b1 && waitCycles < 10) begin
            tick();
            waitCycles++;
        end
        check("t6_tck_up", oTck, 1'b1);
        rstN = 1'b0;
        tick();
        check("t6_tck_rst", oTck, 1'b0);
        rstN = 1'b1;
        base = riseCount;
        tick(10);
        check("t6_no_spurious", riseCount - base, 0);
        rawTck = 1'b0;
        tick(6);
        rawTck = 1'b1;
        tick(6);
        check("t6_next_pulse", riseCount - base, 1);
        rawTck = 1'b0;
        tick(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
